// File: rtl/atm_keypad_if.sv
// Keypad strobe/mode inputs and the registered results offered to the transaction FSM.
// The keypad driver holds master; atm_keypad_entry holds slave.
interface atm_keypad_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic [1:0] entry_mode;
  logic [3:0] pin_out;
  logic [5:0] amount_out;
  logic [1:0] op_out;
  logic       pin_done;
  logic       amount_done;
  logic       op_done;
  logic       exit_req;
  logic       home_req;
  logic       entry_error;
  logic [1:0] digit_count;
  logic       timeout_o;

  modport master (
    output key_valid, key_code, entry_mode,
    input  pin_out, amount_out, op_out, pin_done, amount_done, op_done,
           exit_req, home_req, entry_error, digit_count, timeout_o
  );

  modport slave (
    input  key_valid, key_code, entry_mode,
    output pin_out, amount_out, op_out, pin_done, amount_done, op_done,
           exit_req, home_req, entry_error, digit_count, timeout_o
  );
endinterface

// File: rtl/atm_keypad_entry.sv
// Keypad front-end: two-digit decimal accumulator with range-checked PIN/amount/operation results.
// Optional inactivity abort is built when KEYPAD_TIMEOUT_EN is defined.
module atm_keypad_entry #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int PIN_MAX        = 15,
  parameter int AMT_MAX        = 63
) (
  input  logic        clk,
  input  logic        rst,
  atm_keypad_if.slave kp
);

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

  localparam logic [6:0] PIN_MAX_C = 7'(PIN_MAX);
  localparam logic [6:0] AMT_MAX_C = 7'(AMT_MAX);
  localparam logic [3:0] K_ENTER   = 4'hA;
  localparam logic [3:0] K_CLEAR   = 4'hB;
  localparam logic [3:0] K_CANCEL  = 4'hC;
  localparam logic [3:0] K_HOME    = 4'hD;

  state_t     state_r, state_nxt_s, state_base_s;
  logic [6:0] acc_r, acc_nxt_s, acc_base_s;
  logic [1:0] mode_prev_r;
  logic       mode_chg_s, key_act_s, is_digit_s, timeout_hit_s;

  logic [3:0] pin_r, pin_nxt_s;
  logic [5:0] amount_r, amount_nxt_s;
  logic [1:0] op_r, op_nxt_s;
  logic       pin_done_r, amount_done_r, op_done_r, exit_r, home_r, err_r, timeout_r;
  logic       pin_done_s, amount_done_s, op_done_s, exit_s, home_s, err_s, timeout_s;

  function automatic logic [6:0] acc_push(input logic [6:0] acc, input logic [3:0] d);
    acc_push = (acc << 3) + (acc << 1) + {3'b000, d};
  endfunction

  assign mode_chg_s = (kp.entry_mode != mode_prev_r);
  assign key_act_s  = kp.key_valid && (kp.entry_mode != 2'b11);
  assign is_digit_s = (kp.key_code <= 4'd9);

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt_r;

  // Idle counter: runs only while a partial entry is held and no key arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_r <= '0;
    end else if ((state_r == S_EMPTY) || kp.key_valid || mode_chg_s) begin
      idle_cnt_r <= '0;
    end else begin
      idle_cnt_r <= idle_cnt_r + TW'(1'b1);
    end
  end

  assign timeout_hit_s = (state_r != S_EMPTY) && !kp.key_valid && !mode_chg_s &&
                         (kp.entry_mode != 2'b11) && (idle_cnt_r == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_c = TIMEOUT_CYCLES;
  assign timeout_hit_s = 1'b0;
`endif

  // A mode change or the disabled mode drops the partial entry before any key is applied.
  always_comb begin
    if (mode_chg_s || (kp.entry_mode == 2'b11)) begin
      state_base_s = S_EMPTY;
      acc_base_s   = 7'd0;
    end else begin
      state_base_s = state_r;
      acc_base_s   = acc_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_EMPTY;
      acc_r       <= 7'd0;
      mode_prev_r <= 2'b00;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      mode_prev_r <= kp.entry_mode;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_base_s;
    acc_nxt_s   = acc_base_s;
    if (key_act_s) begin
      if (is_digit_s) begin
        if (kp.entry_mode == 2'b10) begin
          state_nxt_s = S_EMPTY;
          acc_nxt_s   = 7'd0;
        end else begin
          case (state_base_s)
            S_EMPTY: begin state_nxt_s = S_ONE; acc_nxt_s = acc_push(acc_base_s, kp.key_code); end
            S_ONE:   begin state_nxt_s = S_TWO; acc_nxt_s = acc_push(acc_base_s, kp.key_code); end
            S_TWO:   begin state_nxt_s = S_TWO; acc_nxt_s = acc_base_s; end
            default: begin state_nxt_s = S_EMPTY; acc_nxt_s = 7'd0; end
          endcase
        end
      end else begin
        case (kp.key_code)
          K_ENTER, K_CLEAR, K_CANCEL, K_HOME: begin state_nxt_s = S_EMPTY; acc_nxt_s = 7'd0; end
          default:                            begin state_nxt_s = state_base_s; acc_nxt_s = acc_base_s; end
        endcase
      end
    end else if (timeout_hit_s) begin
      state_nxt_s = S_EMPTY;
      acc_nxt_s   = 7'd0;
    end else begin
      state_nxt_s = state_base_s;
      acc_nxt_s   = acc_base_s;
    end
  end

  // Output decode: value updates and the single pulse for this key.
  always_comb begin
    pin_nxt_s     = pin_r;
    amount_nxt_s  = amount_r;
    op_nxt_s      = op_r;
    pin_done_s    = 1'b0;
    amount_done_s = 1'b0;
    op_done_s     = 1'b0;
    exit_s        = 1'b0;
    home_s        = 1'b0;
    err_s         = 1'b0;
    timeout_s     = 1'b0;
    if (key_act_s) begin
      if (is_digit_s) begin
        if (kp.entry_mode == 2'b10) begin
          case (kp.key_code)
            4'd0:    begin op_nxt_s = 2'b11; op_done_s = 1'b1; end
            4'd1:    begin op_nxt_s = 2'b00; op_done_s = 1'b1; end
            4'd2:    begin op_nxt_s = 2'b01; op_done_s = 1'b1; end
            4'd3:    begin op_nxt_s = 2'b10; op_done_s = 1'b1; end
            default: err_s = 1'b1;
          endcase
        end else if (state_base_s == S_TWO) begin
          err_s = 1'b1;
        end else begin
          err_s = 1'b0;
        end
      end else begin
        case (kp.key_code)
          K_ENTER: begin
            if (kp.entry_mode == 2'b10) begin
              err_s = 1'b0;
            end else if (state_base_s == S_EMPTY) begin
              err_s = 1'b1;
            end else if (kp.entry_mode == 2'b00) begin
              if (acc_base_s <= PIN_MAX_C) begin
                pin_nxt_s  = acc_base_s[3:0];
                pin_done_s = 1'b1;
              end else begin
                err_s = 1'b1;
              end
            end else begin
              if ((acc_base_s >= 7'd1) && (acc_base_s <= AMT_MAX_C)) begin
                amount_nxt_s  = acc_base_s[5:0];
                amount_done_s = 1'b1;
              end else begin
                err_s = 1'b1;
              end
            end
          end
          K_CANCEL: exit_s = 1'b1;
          K_HOME:   home_s = 1'b1;
          default:  err_s  = 1'b0;
        endcase
      end
    end else if (timeout_hit_s) begin
      exit_s    = 1'b1;
      timeout_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // Registered result values and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      pin_r         <= 4'd0;
      amount_r      <= 6'd0;
      op_r          <= 2'b00;
      pin_done_r    <= 1'b0;
      amount_done_r <= 1'b0;
      op_done_r     <= 1'b0;
      exit_r        <= 1'b0;
      home_r        <= 1'b0;
      err_r         <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      pin_r         <= pin_nxt_s;
      amount_r      <= amount_nxt_s;
      op_r          <= op_nxt_s;
      pin_done_r    <= pin_done_s;
      amount_done_r <= amount_done_s;
      op_done_r     <= op_done_s;
      exit_r        <= exit_s;
      home_r        <= home_s;
      err_r         <= err_s;
      timeout_r     <= timeout_s;
    end
  end

  // Digit count decoded from the state register.
  always_comb begin
    case (state_r)
      S_ONE:   kp.digit_count = 2'd1;
      S_TWO:   kp.digit_count = 2'd2;
      default: kp.digit_count = 2'd0;
    endcase
  end

  assign kp.pin_out     = pin_r;
  assign kp.amount_out  = amount_r;
  assign kp.op_out      = op_r;
  assign kp.pin_done    = pin_done_r;
  assign kp.amount_done = amount_done_r;
  assign kp.op_done     = op_done_r;
  assign kp.exit_req    = exit_r;
  assign kp.home_req    = home_r;
  assign kp.entry_error = err_r;
  assign kp.timeout_o   = timeout_r;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed self-checking bench for atm_keypad_entry; timeout scenario adapts to KEYPAD_TIMEOUT_EN.
module tb_atm_keypad_entry;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  atm_keypad_if kp_if();

  atm_keypad_entry #(.TIMEOUT_CYCLES(8), .PIN_MAX(15), .AMT_MAX(63)) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp_if)
  );

  always #5 clk = ~clk;

  // Pulse vector order: pin_done, amount_done, op_done, exit_req, home_req, entry_error
  function automatic logic [5:0] pulses();
    return {kp_if.pin_done, kp_if.amount_done, kp_if.op_done,
            kp_if.exit_req, kp_if.home_req, kp_if.entry_error};
  endfunction

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    kp_if.key_valid = 1'b1;
    kp_if.key_code  = code;
    @(negedge clk);
    kp_if.key_valid = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk);
    kp_if.entry_mode = m;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({kp_if.pin_out, kp_if.amount_out, kp_if.op_out, pulses(), kp_if.digit_count, kp_if.timeout_o} !== 21'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got pin=%0d amt=%0d op=%0d pulses=%b dc=%0d to=%b, want all 0",
               kp_if.pin_out, kp_if.amount_out, kp_if.op_out, pulses(), kp_if.digit_count, kp_if.timeout_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_pin_entry();
    press(4'd1);
    tests_run++;
    if (kp_if.digit_count !== 2'd1) begin tests_failed++; $display("FAIL pin_dc1: got %0d want 1", kp_if.digit_count); end
    press(4'd2);
    tests_run++;
    if (kp_if.digit_count !== 2'd2) begin tests_failed++; $display("FAIL pin_dc2: got %0d want 2", kp_if.digit_count); end
    press(4'hA);
    tests_run++;
    if (kp_if.pin_out !== 4'd12 || pulses() !== 6'b100000 || kp_if.digit_count !== 2'd0) begin
      tests_failed++;
      $display("FAIL pin_enter: got pin=%0d pulses=%b dc=%0d want pin=12 pulses=100000 dc=0",
               kp_if.pin_out, pulses(), kp_if.digit_count);
    end
    @(negedge clk);
    tests_run++;
    if (kp_if.pin_done !== 1'b0) begin tests_failed++; $display("FAIL pin_done_width: got %b want 0", kp_if.pin_done); end
  endtask

  task automatic test_amount();
    set_mode(2'b01);
    press(4'd7); press(4'd5); press(4'hA);
    tests_run++;
    if (pulses() !== 6'b000001 || kp_if.amount_out !== 6'd0) begin
      tests_failed++;
      $display("FAIL amt_75: got pulses=%b amt=%0d want pulses=000001 amt=0", pulses(), kp_if.amount_out);
    end
    press(4'd0); press(4'hA);
    tests_run++;
    if (pulses() !== 6'b000001 || kp_if.amount_out !== 6'd0) begin
      tests_failed++;
      $display("FAIL amt_zero: got pulses=%b amt=%0d want pulses=000001 amt=0", pulses(), kp_if.amount_out);
    end
    press(4'd6); press(4'd3); press(4'hA);
    tests_run++;
    if (pulses() !== 6'b010000 || kp_if.amount_out !== 6'd63) begin
      tests_failed++;
      $display("FAIL amt_63: got pulses=%b amt=%0d want pulses=010000 amt=63", pulses(), kp_if.amount_out);
    end
  endtask

  task automatic test_third_digit();
    press(4'd4); press(4'd2); press(4'd9);
    tests_run++;
    if (pulses() !== 6'b000001 || kp_if.digit_count !== 2'd2) begin
      tests_failed++;
      $display("FAIL third_digit: got pulses=%b dc=%0d want pulses=000001 dc=2", pulses(), kp_if.digit_count);
    end
    press(4'hB);
    tests_run++;
    if (pulses() !== 6'b000000 || kp_if.digit_count !== 2'd0) begin
      tests_failed++;
      $display("FAIL clear: got pulses=%b dc=%0d want pulses=000000 dc=0", pulses(), kp_if.digit_count);
    end
  endtask

  task automatic test_operation();
    set_mode(2'b10);
    press(4'd2);
    tests_run++;
    if (kp_if.op_out !== 2'b01 || pulses() !== 6'b001000 || kp_if.digit_count !== 2'd0) begin
      tests_failed++;
      $display("FAIL op_2: got op=%b pulses=%b dc=%0d want op=01 pulses=001000 dc=0", kp_if.op_out, pulses(), kp_if.digit_count);
    end
    press(4'd0);
    tests_run++;
    if (kp_if.op_out !== 2'b11 || pulses() !== 6'b001000) begin
      tests_failed++;
      $display("FAIL op_0: got op=%b pulses=%b want op=11 pulses=001000", kp_if.op_out, pulses());
    end
    press(4'd5);
    tests_run++;
    if (kp_if.op_out !== 2'b11 || pulses() !== 6'b000001) begin
      tests_failed++;
      $display("FAIL op_5: got op=%b pulses=%b want op=11 pulses=000001", kp_if.op_out, pulses());
    end
    press(4'hA);
    tests_run++;
    if (pulses() !== 6'b000000) begin tests_failed++; $display("FAIL op_enter: got pulses=%b want 000000", pulses()); end
    press(4'hC);
    tests_run++;
    if (pulses() !== 6'b000100) begin tests_failed++; $display("FAIL op_cancel: got pulses=%b want 000100", pulses()); end
  endtask

  task automatic test_mode_switch();
    set_mode(2'b00);
    press(4'd5);
    @(negedge clk);
    kp_if.entry_mode = 2'b01;
    @(negedge clk);
    tests_run++;
    if (kp_if.digit_count !== 2'd0) begin tests_failed++; $display("FAIL switch_clear: got dc=%0d want 0", kp_if.digit_count); end
    press(4'hA);
    tests_run++;
    if (pulses() !== 6'b000001 || kp_if.pin_out !== 4'd12) begin
      tests_failed++;
      $display("FAIL switch_enter: got pulses=%b pin=%0d want pulses=000001 pin=12", pulses(), kp_if.pin_out);
    end
    // Key arriving together with a mode change starts a fresh entry under the new mode.
    press(4'd4);
    @(negedge clk);
    kp_if.entry_mode = 2'b00;
    kp_if.key_valid  = 1'b1;
    kp_if.key_code   = 4'd7;
    @(negedge clk);
    kp_if.key_valid  = 1'b0;
    tests_run++;
    if (kp_if.digit_count !== 2'd1) begin tests_failed++; $display("FAIL switch_same_cycle: got dc=%0d want 1", kp_if.digit_count); end
    press(4'hA);
    tests_run++;
    if (pulses() !== 6'b100000 || kp_if.pin_out !== 4'd7) begin
      tests_failed++;
      $display("FAIL switch_pin7: got pulses=%b pin=%0d want pulses=100000 pin=7", pulses(), kp_if.pin_out);
    end
  endtask

  task automatic test_disabled();
    set_mode(2'b11);
    press(4'd1);
    tests_run++;
    if (pulses() !== 6'b000000 || kp_if.digit_count !== 2'd0) begin
      tests_failed++;
      $display("FAIL disabled_digit: got pulses=%b dc=%0d want 000000 dc=0", pulses(), kp_if.digit_count);
    end
    press(4'hC);
    tests_run++;
    if (pulses() !== 6'b000000 || kp_if.op_out !== 2'b11) begin
      tests_failed++;
      $display("FAIL disabled_cancel: got pulses=%b op=%b want 000000 op=11", pulses(), kp_if.op_out);
    end
  endtask

  task automatic test_home_ignore();
    set_mode(2'b00);
    press(4'd7); press(4'hD);
    tests_run++;
    if (pulses() !== 6'b000010 || kp_if.digit_count !== 2'd0) begin
      tests_failed++;
      $display("FAIL home: got pulses=%b dc=%0d want 000010 dc=0", pulses(), kp_if.digit_count);
    end
    press(4'hE);
    tests_run++;
    if (pulses() !== 6'b000000 || kp_if.digit_count !== 2'd0 || kp_if.pin_out !== 4'd7) begin
      tests_failed++;
      $display("FAIL ignored_key: got pulses=%b dc=%0d pin=%0d want 000000 dc=0 pin=7", pulses(), kp_if.digit_count, kp_if.pin_out);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    kp_if.key_valid = 1'b1; kp_if.key_code = 4'd1;
    @(negedge clk);
    tests_run++;
    if (kp_if.digit_count !== 2'd1) begin tests_failed++; $display("FAIL b2b_dc1: got %0d want 1", kp_if.digit_count); end
    kp_if.key_code = 4'd4;
    @(negedge clk);
    tests_run++;
    if (kp_if.digit_count !== 2'd2) begin tests_failed++; $display("FAIL b2b_dc2: got %0d want 2", kp_if.digit_count); end
    kp_if.key_code = 4'hA;
    @(negedge clk);
    kp_if.key_valid = 1'b0;
    tests_run++;
    if (kp_if.pin_out !== 4'd14 || pulses() !== 6'b100000 || kp_if.digit_count !== 2'd0) begin
      tests_failed++;
      $display("FAIL b2b_pin14: got pin=%0d pulses=%b dc=%0d want pin=14 pulses=100000 dc=0",
               kp_if.pin_out, pulses(), kp_if.digit_count);
    end
  endtask

  task automatic test_timeout();
    press(4'd3);
`ifdef KEYPAD_TIMEOUT_EN
    repeat (7) @(negedge clk);
    tests_run++;
    if (kp_if.timeout_o !== 1'b0 || kp_if.digit_count !== 2'd1) begin
      tests_failed++;
      $display("FAIL timeout_early: got to=%b dc=%0d want to=0 dc=1", kp_if.timeout_o, kp_if.digit_count);
    end
    @(negedge clk);
    tests_run++;
    if (kp_if.timeout_o !== 1'b1 || pulses() !== 6'b000100 || kp_if.digit_count !== 2'd0) begin
      tests_failed++;
      $display("FAIL timeout_fire: got to=%b pulses=%b dc=%0d want to=1 pulses=000100 dc=0",
               kp_if.timeout_o, pulses(), kp_if.digit_count);
    end
`else
    repeat (20) @(negedge clk);
    tests_run++;
    if (kp_if.timeout_o !== 1'b0 || kp_if.digit_count !== 2'd1 || pulses() !== 6'b000000) begin
      tests_failed++;
      $display("FAIL no_timeout: got to=%b dc=%0d pulses=%b want to=0 dc=1 pulses=000000",
               kp_if.timeout_o, kp_if.digit_count, pulses());
    end
    press(4'hB);
`endif
  endtask

  task automatic test_reset_mid_entry();
    set_mode(2'b01);
    press(4'd9);
    tests_run++;
    if (kp_if.digit_count !== 2'd1) begin tests_failed++; $display("FAIL rst_mid_dc: got %0d want 1", kp_if.digit_count); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({kp_if.pin_out, kp_if.amount_out, kp_if.op_out, pulses(), kp_if.digit_count, kp_if.timeout_o} !== 21'd0) begin
      tests_failed++;
      $display("FAIL rst_mid: got pin=%0d amt=%0d op=%0d pulses=%b dc=%0d want all 0",
               kp_if.pin_out, kp_if.amount_out, kp_if.op_out, pulses(), kp_if.digit_count);
    end
  endtask

  initial begin
    kp_if.key_valid  = 1'b0;
    kp_if.key_code   = 4'd0;
    kp_if.entry_mode = 2'b00;
    test_reset();
    test_pin_entry();
    test_amount();
    test_third_digit();
    test_operation();
    test_mode_switch();
    test_disabled();
    test_home_ignore();
    test_back_to_back();
    test_timeout();
    test_reset_mid_entry();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 time units");
    $fatal(1);
  end
endmodule
